mac_result_packer: RTL and testbench
====================================

Name: mac_result_packer

Overview:
- Sits directly downstream of the layer-2 convolution datapath.
- Consumes the 12-bit signed MAC results, one per macDone pulse, and requantises each to 8 bits (arithmetic shift plus saturation).
- Packs four consecutive results into a 32-bit word and presents the word with a write address to the layer-2 result memory over a valid/ready handshake.
- Handles end-of-frame flush with zero-padding and reports frame completion.

Parameters:
- SHIFT, 2, arithmetic right-shift applied to each MAC result before saturation (0..11).
- ADR_W, 7, width of the output word address.
- BASE_ADR, 0, address of the first word after reset or clr.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- clr  input  1  synchronous frame restart; same effect as rst, lower priority than rst
- macIn  input  12  signed two's-complement MAC result
- macValid  input  1  macIn valid (driven from macDone)
- macLast  input  1  qualifies macIn as the final result of the frame
- macReady  output  1  block can accept macIn this cycle
- wordOut  output  32  packed word; lane 0 at [7:0], lane 3 at [31:24]
- wordValid  output  1  wordOut/wordAdr valid
- wordReady  input  1  memory side accepts the word
- wordAdr  output  ADR_W  write address of wordOut
- frameDone  output  1  one-cycle pulse when the last word of the frame is accepted
- wordCount  output  ADR_W+1  words accepted since rst/clr

Behaviour:
- Reset (rst async, or clr sync) values:
  - laneCnt=0, pack register=0.
  - wordOut=0, wordValid=0, wordAdr=BASE_ADR, frameDone=0, wordCount=0.
  - macReady=1, since macReady is derived from wordValid.
- Requantise, per sample:
  - s = macIn >>> SHIFT (sign-extending).
  - Default: saturate to [-128,127]; the 8-bit lane value is s[7:0] after clamping.
- Handshake rules:
  - macReady = !wordValid || wordReady (combinational).
  - Input accepted when macValid && macReady.
  - Word accepted when wordValid && wordReady.
- Packing:
  - On each accepted input, the requantised byte is written to lane laneCnt and laneCnt increments.
- Word load:
  - Triggered when the accepted input has laneCnt==3 or macLast=1.
  - wordOut <= pack register with the current byte merged in; lanes above the current lane are forced to 0.
  - wordValid <= 1 on the next edge; laneCnt <= 0; pack register cleared.
  - The internal lastPending flag is set to macLast.
- Word accept:
  - wordAdr increments on the edge after acceptance, wrapping modulo 2^ADR_W.
  - wordCount increments, saturating at all-ones.
  - wordValid drops unless a new word loads in the same cycle.
- Simultaneous accept and load in one cycle:
  - The new word replaces the old one and wordValid stays 1.
  - wordAdr advances exactly once.
  - Throughput is therefore 1 input/cycle with no bubbles while wordReady=1.
- Latency: from the accepted 4th or last input to wordValid is 1 cycle.
- frameDone:
  - Asserted for one cycle on the edge following acceptance of a word with lastPending=1.
  - wordAdr and wordCount are not reset by frameDone; only rst/clr restart them.
- Backpressure:
  - While wordValid=1 and wordReady=0, macReady=0.
  - wordOut and wordAdr are held stable.
  - No input is dropped.
- Other boundary cases:
  - macLast on lane 0 produces a word with lanes 1-3 = 0.
  - macValid while macReady=0 is ignored; upstream must hold.
  - rst mid-word discards partial lanes and any pending word.

Optional Feature:
- Macro: PACKER_RELU_EN.
- Defined: ReLU requantisation.
  - s<0 gives 0.
  - s>255 saturates to 255.
  - Otherwise the lane is s[7:0], unsigned.
- Undefined: signed saturation to [-128,127] as described in Behaviour.

Test Plan:
- SHIFT=2, wordReady=1; inputs 12'h004, 12'h008, 12'h00C, 12'h7FF (last on the 4th) -> wordOut=32'h7F030201 at wordAdr=0, one cycle after the 4th input; frameDone pulses on the next cycle; wordCount=1.
- Input 12'hF00 (-256) in lane 0, then 3 zeros -> wordOut=32'h000000C0; with PACKER_RELU_EN -> 32'h00000000. With PACKER_RELU_EN, 12'h7FF -> lane 8'hFF.
- Partial flush: inputs 12'h004, 12'h008 with macLast on the 2nd -> wordOut=32'h00000201, wordValid 1 cycle later, frameDone after acceptance.
- Backpressure: stream 8 inputs with wordReady=0 for 5 cycles after the first word loads -> macReady=0 for those cycles; wordOut/wordAdr stable; both words arrive in order at adr 0 and 1; no loss.
- Wrap: ADR_W=2; stream 20 inputs -> words at adr 0,1,2,3,0; wordCount=5.
- Reset: assert rst asynchronously after 2 inputs -> all outputs are at reset values immediately (before the next edge); the next 4 inputs form a word at BASE_ADR. clr with a word pending -> wordValid=0 next cycle.

Source files
------------

// File: rtl/mac_result_packer.sv
// Requantises 12-bit signed MAC results to bytes and packs four per 32-bit word
// for the layer-2 result memory. Define PACKER_RELU_EN for ReLU (unsigned) lanes.
module mac_result_packer #(
  parameter int SHIFT    = 2,
  parameter int ADR_W    = 7,
  parameter int BASE_ADR = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic [11:0]        macIn,
  input  logic               macValid,
  input  logic               macLast,
  output logic               macReady,
  output logic [31:0]        wordOut,
  output logic               wordValid,
  input  logic               wordReady,
  output logic [ADR_W-1:0]   wordAdr,
  output logic               frameDone,
  output logic [ADR_W:0]     wordCount
);

  logic [1:0]         laneCnt;
  logic [31:0]        packReg;
  logic               lastPending;
  logic signed [11:0] shifted;
  logic [7:0]         laneByte;
  logic [31:0]        merged;
  logic               inAcc;
  logic               wordAcc;
  logic               loadWord;

  assign macReady = !wordValid || wordReady;
  assign inAcc    = macValid && macReady;
  assign wordAcc  = wordValid && wordReady;
  assign loadWord = inAcc && (laneCnt == 2'd3 || macLast);

  always_comb begin
    shifted = $signed(macIn) >>> SHIFT;
`ifdef PACKER_RELU_EN
    if (shifted < 0)
      laneByte = '0;
    else if (shifted > 12'sd255)
      laneByte = '1;
    else
      laneByte = shifted[7:0];
`else
    if (shifted > 12'sd127)
      laneByte = 8'h7F;
    else if (shifted < -12'sd128)
      laneByte = 8'h80;
    else
      laneByte = shifted[7:0];
`endif
  end

  // Lanes above the current one are zeroed so an early macLast pads the word.
  always_comb begin
    merged = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (i < 32'(laneCnt))
        merged[8*i +: 8] = packReg[8*i +: 8];
      else if (i == 32'(laneCnt))
        merged[8*i +: 8] = laneByte;
      else
        merged[8*i +: 8] = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      laneCnt     <= '0;
      packReg     <= '0;
      lastPending <= 1'b0;
      wordOut     <= '0;
      wordValid   <= 1'b0;
      wordAdr     <= ADR_W'(BASE_ADR);
      frameDone   <= 1'b0;
      wordCount   <= '0;
    end else if (clr) begin
      laneCnt     <= '0;
      packReg     <= '0;
      lastPending <= 1'b0;
      wordOut     <= '0;
      wordValid   <= 1'b0;
      wordAdr     <= ADR_W'(BASE_ADR);
      frameDone   <= 1'b0;
      wordCount   <= '0;
    end else begin
      frameDone <= wordAcc && lastPending;
      if (wordAcc) begin
        wordAdr <= wordAdr + 1'b1;
        if (wordCount != '1)
          wordCount <= wordCount + 1'b1;
      end
      if (loadWord) begin
        wordOut     <= merged;
        packReg     <= '0;
        laneCnt     <= '0;
        lastPending <= macLast;
      end else if (inAcc) begin
        packReg <= merged;
        laneCnt <= laneCnt + 1'b1;
      end
      // A load in the same cycle as an accept replaces the word without a bubble.
      if (loadWord)
        wordValid <= 1'b1;
      else if (wordAcc)
        wordValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mac_result_packer.sv
// Scoreboard bench for mac_result_packer: driver feeds a byte-list reference
// model, a monitor pops expected words whenever a word is handed over.
module tb_mac_result_packer;
  localparam int AW    = 2;
  localparam int SHIFT = 2;

  logic            clk = 1'b0;
  logic            rst, clr;
  logic [11:0]     macIn;
  logic            macValid, macLast, macReady;
  logic [31:0]     wordOut;
  logic            wordValid, wordReady;
  logic [AW-1:0]   wordAdr;
  logic            frameDone;
  logic [AW:0]     wordCount;

  mac_result_packer #(.SHIFT(SHIFT), .ADR_W(AW), .BASE_ADR(0)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .macIn(macIn), .macValid(macValid), .macLast(macLast), .macReady(macReady),
    .wordOut(wordOut), .wordValid(wordValid), .wordReady(wordReady),
    .wordAdr(wordAdr), .frameDone(frameDone), .wordCount(wordCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    int          adr;
    bit          last;
  } expT;

  expT          q[$];
  logic [7:0]   bytes[$];
  int           modelAdr;
  int           accCnt;
  bit           expFd;
  bit           prevHeld;
  logic [31:0]  heldWord;
  logic [AW-1:0] heldAdr;
  int           checks = 0;
  int           errors = 0;
  int           readyMode = 1;
  int           stallCycles = 0;
  bit           lastLoaded;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] refQuant(input logic [11:0] m);
    int v;
    v = int'($signed(m));
    v = v >>> SHIFT;
`ifdef PACKER_RELU_EN
    if (v < 0) v = 0;
    if (v > 255) v = 255;
`else
    if (v < -128) v = -128;
    if (v > 127) v = 127;
`endif
    return v[7:0];
  endfunction

  function automatic bit modelPush(input logic [11:0] d, input bit last);
    logic [31:0] w;
    bytes.push_back(refQuant(d));
    if (bytes.size() == 4 || last) begin
      w = '0;
      foreach (bytes[i]) w[8*i +: 8] = bytes[i];
      q.push_back('{word: w, adr: modelAdr, last: last});
      modelAdr = (modelAdr + 1) % (1 << AW);
      bytes.delete();
      return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic void clearModel();
    q.delete();
    bytes.delete();
    modelAdr = 0;
    accCnt   = 0;
    expFd    = 1'b0;
    prevHeld = 1'b0;
  endfunction

  function automatic logic nextReady();
    if (stallCycles > 0) begin
      stallCycles--;
      return 1'b0;
    end
    case (readyMode)
      0:       return 1'b0;
      1:       return 1'b1;
      default: return $urandom_range(0, 3) != 0;
    endcase
  endfunction

  task automatic sendMac(input logic [11:0] d, input bit last);
    bit done;
    int tries;
    done = 1'b0;
    tries = 0;
    lastLoaded = 1'b0;
    while (!done) begin
      @(negedge clk);
      macIn = d; macValid = 1'b1; macLast = last; wordReady = nextReady();
      #1;
      if (macReady) begin
        lastLoaded = modelPush(d, last);
        @(posedge clk);
        #1;
        if (lastLoaded) chk("load_latency", 32'(wordValid), 32'd1);
        done = 1'b1;
      end else begin
        tries++;
        if (tries > 200) begin
          chk("accept_timeout", 32'd0, 32'd1);
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      macValid = 1'b0; macLast = 1'b0; wordReady = nextReady();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while ((q.size() != 0 || wordValid) && n < 500) begin
      @(negedge clk);
      macValid = 1'b0; macLast = 1'b0; wordReady = nextReady();
      #3;
      n++;
    end
    if (n >= 500) chk("drain_timeout", 32'd0, 32'd1);
    idle(2);
  endtask

  task automatic doClr();
    @(negedge clk);
    macValid = 1'b0; wordReady = 1'b0; clr = 1'b1;
    #1;
    clearModel();
    @(posedge clk);
    #1;
    chk("clr_wordValid", 32'(wordValid), 32'd0);
    chk("clr_wordAdr", 32'(wordAdr), 32'd0);
    chk("clr_wordCount", 32'(wordCount), 32'd0);
    @(negedge clk);
    clr = 1'b0; wordReady = nextReady();
  endtask

  // Monitor: one sample per cycle on the falling edge, after the driver settles.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst && !clr) begin
        chk("frameDone", 32'(frameDone), 32'(expFd));
        chk("wordCount", 32'(wordCount), 32'((accCnt > 7) ? 7 : accCnt));
        chk("macReady", 32'(macReady), 32'(!wordValid || wordReady));
        if (prevHeld && wordValid) begin
          chk("hold_word", wordOut, heldWord);
          chk("hold_adr", 32'(wordAdr), 32'(heldAdr));
        end
        prevHeld = wordValid && !wordReady;
        heldWord = wordOut;
        heldAdr  = wordAdr;
        expFd    = 1'b0;
        if (wordValid && wordReady) begin
          if (q.size() == 0) begin
            chk("unexpected_word", wordOut, 32'hDEADBEEF);
          end else begin
            expT e;
            e = q.pop_front();
            chk("word", wordOut, e.word);
            chk("word_adr", 32'(wordAdr), 32'(e.adr));
            expFd = e.last;
            accCnt++;
          end
        end
      end
    end
  end

  initial begin
    logic [11:0] d;
    rst = 1'b1; clr = 1'b0; macIn = '0; macValid = 1'b0; macLast = 1'b0; wordReady = 1'b0;
    clearModel();
    repeat (2) @(negedge clk);
    chk("rst_wordValid", 32'(wordValid), 32'd0);
    chk("rst_wordOut", wordOut, 32'd0);
    chk("rst_macReady", 32'(macReady), 32'd1);
    chk("rst_wordCount", 32'(wordCount), 32'd0);
    rst = 1'b0;

    // Fixed vectors, always ready
    readyMode = 1;
    sendMac(12'h004, 1'b0); sendMac(12'h008, 1'b0); sendMac(12'h00C, 1'b0);
    sendMac(12'h7FF, 1'b1);
`ifdef PACKER_RELU_EN
    chk("t1_word", wordOut, 32'hFF030201);
`else
    chk("t1_word", wordOut, 32'h7F030201);
`endif
    chk("t1_adr", 32'(wordAdr), 32'd0);
    idle(2);
    chk("t1_count", 32'(wordCount), 32'd1);

    sendMac(12'hF00, 1'b0); sendMac(12'h000, 1'b0); sendMac(12'h000, 1'b0);
    sendMac(12'h000, 1'b0);
`ifdef PACKER_RELU_EN
    chk("t2_neg", wordOut, 32'h00000000);
`else
    chk("t2_neg", wordOut, 32'h000000C0);
`endif

    sendMac(12'h004, 1'b0); sendMac(12'h008, 1'b1);
    chk("t3_partial", wordOut, 32'h00000201);
    waitDrain();

    // Backpressure for 5 cycles after the first word loads
    doClr();
    for (int i = 0; i < 4; i++) sendMac(12'(16 * (i + 1)), 1'b0);
    stallCycles = 5;
    for (int i = 4; i < 8; i++) sendMac(12'(16 * (i + 1)), i == 7);
    waitDrain();
    chk("bp_count", 32'(wordCount), 32'd2);

    // Address wrap with 2-bit addresses
    doClr();
    for (int i = 0; i < 20; i++) sendMac(12'($urandom), 1'b0);
    waitDrain();
    chk("wrap_count", 32'(wordCount), 32'd5);
    chk("wrap_adr", 32'(wordAdr), 32'd1);

    // Asynchronous reset mid-word
    sendMac(12'h100, 1'b0); sendMac(12'h200, 1'b0);
    @(negedge clk);
    macValid = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    clearModel();
    chk("arst_wordOut", wordOut, 32'd0);
    chk("arst_wordValid", 32'(wordValid), 32'd0);
    chk("arst_wordAdr", 32'(wordAdr), 32'd0);
    chk("arst_frameDone", 32'(frameDone), 32'd0);
    chk("arst_wordCount", 32'(wordCount), 32'd0);
    chk("arst_macReady", 32'(macReady), 32'd1);
    @(negedge clk);
    rst = 1'b0; wordReady = nextReady();
    for (int i = 0; i < 4; i++) sendMac(12'(8 * i + 4), 1'b0);
    chk("arst_word", wordOut, 32'h07050301);
    chk("arst_base", 32'(wordAdr), 32'd0);
    waitDrain();

    // clr while a word is pending
    readyMode = 0;
    for (int i = 0; i < 4; i++) sendMac(12'h040, 1'b0);
    chk("clr_pending", 32'(wordValid), 32'd1);
    doClr();

    // Randomised traffic with random backpressure and frame ends
    readyMode = 2;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 4) == 0) idle(1);
      case ($urandom_range(0, 5))
        0:       d = 12'h7FF;
        1:       d = 12'h800;
        2:       d = 12'($urandom_range(0, 1023));
        default: d = 12'($urandom);
      endcase
      sendMac(d, $urandom_range(0, 9) == 0);
    end
    readyMode = 1;
    waitDrain();
    chk("final_count", 32'(wordCount), 32'((accCnt > 7) ? 7 : accCnt));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
